// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS control unit: opcodes, functs, ALU op codes, states.
// Pure definitions, no logic; SHIFT_LUI_EN consumers decide which encodings are legal.
package mips_pkg;

  localparam int STATE_W = 4;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL = 6'h00;
  localparam logic [5:0] FN_SRL = 6'h02;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_NOR = 6'h27;

  typedef enum logic [3:0] {
    ALU_AND = 4'b0000,
    ALU_OR  = 4'b0001,
    ALU_NOR = 4'b0010,
    ALU_ADD = 4'b0011,
    ALU_SUB = 4'b0100,
    ALU_SLL = 4'b0101,
    ALU_SRL = 4'b0110,
    ALU_LUI = 4'b0111
  } alu_op_t;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_EXEC   = 4'd3,
    S_RWB    = 4'd4,
    S_MEMADR = 4'd5,
    S_MEMRD  = 4'd6,
    S_MEMWB  = 4'd7,
    S_MEMWR  = 4'd8,
    S_BRANCH = 4'd9,
    S_JUMP   = 4'd10,
    S_IEXEC  = 4'd11,
    S_IWB    = 4'd12
  } state_t;

  typedef enum logic [1:0] {
    SRCB_REGB   = 2'b00,
    SRCB_FOUR   = 2'b01,
    SRCB_IMM    = 2'b10,
    SRCB_IMMSH2 = 2'b11
  } alusrcb_t;

  typedef enum logic [1:0] {
    PCSRC_ALU    = 2'b00,
    PCSRC_ALUOUT = 2'b01,
    PCSRC_JUMP   = 2'b10
  } pcsource_t;

endpackage

// File: rtl/alu_op_decoder.sv
// R-type Funct -> ALU op code plus legality flag; purely combinational, no backpressure.
// sll/srl are only legal when SHIFT_LUI_EN is defined.
module alu_op_decoder
  import mips_pkg::*;
(
  input  logic [5:0] funct,
  output alu_op_t    alu_op,
  output logic       legal
);

  always_comb begin
    alu_op = ALU_AND;
    legal  = 1'b1;
    case (funct)
      FN_ADD: alu_op = ALU_ADD;
      FN_SUB: alu_op = ALU_SUB;
      FN_AND: alu_op = ALU_AND;
      FN_OR:  alu_op = ALU_OR;
      FN_NOR: alu_op = ALU_NOR;
`ifdef SHIFT_LUI_EN
      FN_SLL: alu_op = ALU_SLL;
      FN_SRL: alu_op = ALU_SRL;
`else
      FN_SLL: legal = 1'b0;
      FN_SRL: legal = 1'b0;
`endif
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multicycle MIPS control: FETCH..WRITEBACK sequencing, 3-5 cycles per instruction, never stalls.
// Outputs decode from state (plus Zero in BRANCH); SHIFT_LUI_EN enables sll/srl/lui.
module multicycle_control_fsm
  import mips_pkg::*;
#(
  parameter int STATE_W = mips_pkg::STATE_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [5:0]         Opcode,
  input  logic [5:0]         Funct,
  input  logic               Zero,
  output logic [3:0]         ALUOperation,
  output logic               ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic               ExtZero,
  output logic [1:0]         PCSource,
  output logic               PCWrite,
  output logic               IorD,
  output logic               MemRead,
  output logic               MemWrite,
  output logic               IRWrite,
  output logic               RegDst,
  output logic               MemtoReg,
  output logic               RegWrite,
  output logic               IllegalInstr,
  output logic [STATE_W-1:0] State
);

  state_t  state_q, state_d;
  alu_op_t fn_op;
  logic    fn_legal;

  alu_op_decoder u_alu_op_decoder (
    .funct  (Funct),
    .alu_op (fn_op),
    .legal  (fn_legal)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  assign State = state_q;

  always_comb begin
    state_d      = state_q;
    ALUOperation = ALU_AND;
    ALUSrcA      = 1'b0;
    ALUSrcB      = SRCB_REGB;
    ExtZero      = 1'b0;
    PCSource     = PCSRC_ALU;
    PCWrite      = 1'b0;
    IorD         = 1'b0;
    MemRead      = 1'b0;
    MemWrite     = 1'b0;
    IRWrite      = 1'b0;
    RegDst       = 1'b0;
    MemtoReg     = 1'b0;
    RegWrite     = 1'b0;
    IllegalInstr = 1'b0;
    case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        MemRead      = 1'b1;
        IRWrite      = 1'b1;
        PCWrite      = 1'b1;
        ALUSrcB      = SRCB_FOUR;
        ALUOperation = ALU_ADD;
        PCSource     = PCSRC_ALU;
        state_d      = S_DECODE;
      end
      S_DECODE: begin
        // ALU precomputes the branch target while the opcode is decoded
        ALUSrcB      = SRCB_IMMSH2;
        ALUOperation = ALU_ADD;
        IllegalInstr = 1'b1;
        state_d      = S_FETCH;
        case (Opcode)
          OP_RTYPE: if (fn_legal) begin IllegalInstr = 1'b0; state_d = S_EXEC; end
          OP_LW, OP_SW:   begin IllegalInstr = 1'b0; state_d = S_MEMADR; end
          OP_BEQ, OP_BNE: begin IllegalInstr = 1'b0; state_d = S_BRANCH; end
          OP_J:           begin IllegalInstr = 1'b0; state_d = S_JUMP;   end
          OP_ADDI, OP_ANDI, OP_ORI: begin IllegalInstr = 1'b0; state_d = S_IEXEC; end
`ifdef SHIFT_LUI_EN
          OP_LUI:         begin IllegalInstr = 1'b0; state_d = S_IEXEC; end
`else
          OP_LUI:         IllegalInstr = 1'b1;
`endif
          default:        IllegalInstr = 1'b1;
        endcase
      end
      S_EXEC: begin
        ALUSrcA      = 1'b1;
        ALUSrcB      = SRCB_REGB;
        ALUOperation = fn_op;
        state_d      = S_RWB;
      end
      S_RWB: begin
        RegDst   = 1'b1;
        RegWrite = 1'b1;
        state_d  = S_FETCH;
      end
      S_MEMADR: begin
        ALUSrcA      = 1'b1;
        ALUSrcB      = SRCB_IMM;
        ALUOperation = ALU_ADD;
        state_d      = (Opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        IorD    = 1'b1;
        MemRead = 1'b1;
        state_d = S_MEMWB;
      end
      S_MEMWB: begin
        MemtoReg = 1'b1;
        RegWrite = 1'b1;
        state_d  = S_FETCH;
      end
      S_MEMWR: begin
        IorD     = 1'b1;
        MemWrite = 1'b1;
        state_d  = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcA      = 1'b1;
        ALUSrcB      = SRCB_REGB;
        ALUOperation = ALU_SUB;
        PCSource     = PCSRC_ALUOUT;
        PCWrite      = (Opcode == OP_BEQ) ? Zero : ~Zero;
        state_d      = S_FETCH;
      end
      S_JUMP: begin
        PCSource = PCSRC_JUMP;
        PCWrite  = 1'b1;
        state_d  = S_FETCH;
      end
      S_IEXEC: begin
        ALUSrcA      = 1'b1;
        ALUSrcB      = SRCB_IMM;
        ALUOperation = ALU_ADD;
        case (Opcode)
          OP_ANDI: begin ALUOperation = ALU_AND; ExtZero = 1'b1; end
          OP_ORI:  begin ALUOperation = ALU_OR;  ExtZero = 1'b1; end
`ifdef SHIFT_LUI_EN
          OP_LUI:  ALUOperation = ALU_LUI;
`endif
          default: ALUOperation = ALU_ADD;
        endcase
        state_d = S_IWB;
      end
      S_IWB: begin
        RegWrite = 1'b1;
        state_d  = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end

endmodule
